instruction_fetch: RTL and testbench

IF stage. Holds the PC, fetches from instruction memory over a req/ready handshake, and presents instruction + PC to the ID stage.
- ID decodes if_instr and drives the register_file read addresses.
- if_no_op marks bubbles and travels down the pipe to become wb_no_op.
- Handles stall from the hazard unit and redirect (branch/jump) from EX.

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 13 +
 rtl/instruction_fetch_if_id_reg.sv | 35 +++
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch (IF) stage.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
package instruction_fetch_pkg;

  localparam int ISA_WIDTH = 32;

  typedef logic [ISA_WIDTH-1:0] word_t;

  // sll $0,$0,0 encodes as all zeros
  localparam word_t NOP_WORD = '0;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory req/ready bus between the IF stage (master) and memory (slave).
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic  req;
  word_t addr;
  logic  ready;
  word_t rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);

endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// Pipeline register with hold (stall) and bubble-insert (flush); flush wins over hold.
module instruction_fetch_if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  flush,
  input  word_t d_pc,
  input  word_t d_instr,
  output word_t q_pc,
  output word_t q_pc_plus4,
  output word_t q_instr,
  output logic  q_no_op
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_pc       <= '0;
      q_pc_plus4 <= '0;
      q_instr    <= NOP_INSTR;
      q_no_op    <= 1'b1;
    end else if (!hold) begin
      q_pc       <= d_pc;
      q_pc_plus4 <= d_pc + ISA_WIDTH'(4);
      q_instr    <= d_instr;
      q_no_op    <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, req/ready fetch FSM, stall/redirect handling, IF/ID register.
// Define FETCH_MISALIGN_TRAP_EN to add if_misalign and trap misaligned redirects.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect_en,
  input  word_t                      redirect_pc,
  instruction_fetch_if.master        imem,
  output word_t                      if_pc,
  output word_t                      if_pc_plus4,
  output word_t                      if_instr,
  output logic                       if_no_op
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                       if_misalign
`endif
);

  if_state_e state, state_next;
  word_t     pc, pc_next;
  word_t     target, target_next;
  word_t     buf_word, buf_next;
  word_t     load_instr;
  word_t     new_pc;
  logic      fetch_en;
  logic      req;
  logic      load;
  logic      flush;
  logic      misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt;
  assign misaligned = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
  localparam logic halt = 1'b0;
  assign misaligned = 1'b0;
`endif

  // A trapped redirect leaves pc at its last aligned value.
  assign new_pc = misaligned ? pc : align_word(redirect_pc);

  // NOTE: every variable written below gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    target_next = target;
    buf_next    = buf_word;
    req         = 1'b0;
    load        = 1'b0;
    load_instr  = imem.rdata;

    unique case (state)
      IF_REQ: begin
        if (redirect_en) begin
          pc_next = new_pc;
        end else if (fetch_en && !stall && !halt) begin
          req        = 1'b1;
          state_next = IF_WAIT;
        end
      end
      IF_WAIT: begin
        req = 1'b1;
        if (imem.ready) begin
          // A response coinciding with a redirect closes the transaction,
          // so there is nothing left to drain.
          if (redirect_en) begin
            pc_next    = new_pc;
            state_next = IF_REQ;
          end else if (stall) begin
            buf_next   = imem.rdata;
            state_next = IF_HOLD;
          end else begin
            load       = 1'b1;
            pc_next    = pc + ISA_WIDTH'(4);
            state_next = IF_REQ;
          end
        end else if (redirect_en) begin
          target_next = new_pc;
          state_next  = IF_DROP;
        end
      end
      IF_DROP: begin
        req = 1'b1;
        if (redirect_en && !misaligned) target_next = align_word(redirect_pc);
        if (imem.ready) begin
          pc_next    = target_next;
          state_next = IF_REQ;
        end
      end
      IF_HOLD: begin
        if (redirect_en) begin
          pc_next    = new_pc;
          state_next = IF_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = buf_word;
          pc_next    = pc + ISA_WIDTH'(4);
          state_next = IF_REQ;
        end
      end
      default: state_next = IF_REQ;
    endcase
  end

  assign imem.req  = req;
  assign imem.addr = pc;
  assign flush     = redirect_en || (!stall && !load);

  // fetch_en keeps imem_req low for the first cycle after reset while memory settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IF_REQ;
      pc       <= RESET_PC;
      target   <= RESET_PC;
      fetch_en <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      target   <= target_next;
      fetch_en <= 1'b1;
    end
  end

  // NOTE: the buffer has no reset; it is only read in IF_HOLD, after being written.
  always_ff @(posedge clk) begin
    buf_word <= buf_next;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halt        <= 1'b0;
      if_misalign <= 1'b0;
    end else begin
      if (redirect_en) halt <= misaligned;
      if_misalign <= misaligned;
    end
  end
`endif

  instruction_fetch_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .flush     (flush),
    .d_pc      (pc),
    .d_instr   (load_instr),
    .q_pc      (if_pc),
    .q_pc_plus4(if_pc_plus4),
    .q_instr   (if_instr),
    .q_no_op   (if_no_op)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a variable-latency memory model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam word_t NOP    = 32'h0000_0000;
  localparam word_t KEY    = 32'h1234_5678;

  logic  clk = 1'b0;
  logic  rst;
  logic  stall;
  logic  redirect_en;
  word_t redirect_pc;
  word_t if_pc, if_pc_plus4, if_instr;
  logic  if_no_op;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic  if_misalign;
`endif

  int    checks = 0;
  int    errors = 0;
  int    mem_lat = 1;
  logic  mem_busy;
  int    mem_cnt;
  word_t mem_addr;
  word_t issued[$];

  instruction_fetch_if imem ();

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem       (imem),
    .if_pc      (if_pc),
    .if_pc_plus4(if_pc_plus4),
    .if_instr   (if_instr),
    .if_no_op   (if_no_op)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic word_t mem_word(input word_t a);
    return a ^ KEY;
  endfunction

  // Memory: accepts a request, answers mem_lat edges later, holds ready until taken.
  always @(posedge clk) begin
    if (rst) begin
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      imem.ready <= 1'b0;
    end else if (imem.ready && imem.req) begin
      imem.ready <= 1'b0;
      mem_busy   <= 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem.ready <= 1'b1;
        imem.rdata <= mem_word(mem_addr);
      end
      mem_cnt <= mem_cnt - 1;
    end else if (imem.req) begin
      mem_busy <= 1'b1;
      mem_addr <= imem.addr;
      issued.push_back(imem.addr);
      if (mem_lat == 1) begin
        imem.ready <= 1'b1;
        imem.rdata <= mem_word(imem.addr);
      end else begin
        mem_cnt <= mem_lat - 1;
      end
    end
  end

  task automatic next_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (if_no_op === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no valid fetch within 40 cycles, if_no_op=%b expected 0", name, if_no_op);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; mem_lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issued.delete();
    checks += 5;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem.req); end
    if (if_no_op !== 1'b1) begin errors++; $display("FAIL reset_no_op: got %b expected 1", if_no_op); end
    if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
    if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 0", if_pc_plus4); end
  endtask

  task automatic test_sequential;
    word_t exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = word_t'(i * 4);
      next_valid("seq_valid");
      checks += 3;
      if (if_pc !== exp_pc) begin errors++; $display("FAIL seq_pc: got %h expected %h", if_pc, exp_pc); end
      if (if_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc_plus4: got %h expected %h", if_pc_plus4, exp_pc + 32'd4); end
      if (if_instr !== (exp_pc ^ KEY)) begin errors++; $display("FAIL seq_instr: got %h expected %h", if_instr, exp_pc ^ KEY); end
    end
    checks++;
    if (issued.size() != 3) begin errors++; $display("FAIL seq_issue_count: got %0d expected 3", issued.size()); end
    for (int i = 0; i < 3 && i < issued.size(); i++) begin
      checks++;
      if (issued[i] !== word_t'(i * 4)) begin errors++; $display("FAIL seq_addr: got %h expected %h", issued[i], i * 4); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (if_pc !== 32'h8) begin errors++; $display("FAIL stall_pc: got %h expected 8", if_pc); end
      if (if_no_op !== 1'b0) begin errors++; $display("FAIL stall_no_op: got %b expected 0", if_no_op); end
      if (imem.req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem.req); end
    end
    stall = 1'b0;
    next_valid("stall_release");
    checks += 3;
    if (if_pc !== 32'hC) begin errors++; $display("FAIL stall_next_pc: got %h expected c", if_pc); end
    if (if_instr !== (32'hC ^ KEY)) begin errors++; $display("FAIL stall_next_instr: got %h expected %h", if_instr, 32'hC ^ KEY); end
    if (issued.size() != 4) begin errors++; $display("FAIL stall_issue_count: got %0d expected 4", issued.size()); end
  endtask

  task automatic test_stall_hold;
    mem_lat = 3;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (if_no_op !== 1'b1) begin errors++; $display("FAIL hold_frozen: got %b expected 1", if_no_op); end
    end
    checks++;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b expected 0", imem.req); end
    stall = 1'b0;
    next_valid("hold_release");
    checks += 2;
    if (if_pc !== 32'h10) begin errors++; $display("FAIL hold_pc: got %h expected 10", if_pc); end
    if (if_instr !== (32'h10 ^ KEY)) begin errors++; $display("FAIL hold_instr: got %h expected %h", if_instr, 32'h10 ^ KEY); end
    next_valid("hold_follow");
    checks += 2;
    if (if_pc !== 32'h14) begin errors++; $display("FAIL hold_follow_pc: got %h expected 14", if_pc); end
    if (issued.size() != 6) begin errors++; $display("FAIL hold_issue_count: got %0d expected 6", issued.size()); end
  endtask

  task automatic test_redirect_wait;
    int sz;
    @(negedge clk);
    sz = issued.size();
    redirect_en = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_en = 1'b0;
    checks += 3;
    if (if_no_op !== 1'b1) begin errors++; $display("FAIL redir_bubble: got %b expected 1", if_no_op); end
    if (imem.req !== 1'b1) begin errors++; $display("FAIL redir_drop_req: got %b expected 1", imem.req); end
    if (imem.addr !== 32'h18) begin errors++; $display("FAIL redir_drop_addr: got %h expected 18", imem.addr); end
    next_valid("redir_valid");
    checks += 4;
    if (if_pc !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h expected 40", if_pc); end
    if (if_instr !== (32'h40 ^ KEY)) begin errors++; $display("FAIL redir_instr: got %h expected %h", if_instr, 32'h40 ^ KEY); end
    if (issued.size() != sz + 1) begin errors++; $display("FAIL redir_issue_count: got %0d expected %0d", issued.size(), sz + 1); end
    if (issued[sz] !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h expected 40", issued[sz]); end
  endtask

  task automatic test_stall_redirect;
    mem_lat = 1;
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_en = 1'b0;
    checks += 4;
    if (if_no_op !== 1'b1) begin errors++; $display("FAIL sr_bubble: got %b expected 1", if_no_op); end
    if (if_instr !== NOP) begin errors++; $display("FAIL sr_instr: got %h expected %h", if_instr, NOP); end
    if (imem.addr !== 32'h80) begin errors++; $display("FAIL sr_addr: got %h expected 80", imem.addr); end
    if (imem.req !== 1'b0) begin errors++; $display("FAIL sr_req: got %b expected 0", imem.req); end
    @(negedge clk);
    stall = 1'b0;
    next_valid("sr_valid");
    checks += 2;
    if (if_pc !== 32'h80) begin errors++; $display("FAIL sr_pc: got %h expected 80", if_pc); end
    if (issued[$] !== 32'h80) begin errors++; $display("FAIL sr_last_addr: got %h expected 80", issued[$]); end
  endtask

  task automatic test_wrap;
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_en = 1'b0;
    next_valid("wrap_top");
    checks += 2;
    if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", if_pc); end
    if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4: got %h expected 0", if_pc_plus4); end
    next_valid("wrap_next");
    checks += 3;
    if (if_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h expected 0", if_pc); end
    if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_next_plus4: got %h expected 4", if_pc_plus4); end
    if (issued[$] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", issued[$]); end
  endtask

  task automatic test_reset_in_wait;
    mem_lat = 3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rstw_req: got %b expected 0", imem.req); end
    if (if_no_op !== 1'b1) begin errors++; $display("FAIL rstw_no_op: got %b expected 1", if_no_op); end
    if (if_instr !== NOP) begin errors++; $display("FAIL rstw_instr: got %h expected %h", if_instr, NOP); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL rstw_pc: got %h expected 0", if_pc); end
    rst = 1'b0;
    issued.delete();
    next_valid("rstw_valid");
    checks += 2;
    if (issued[0] !== 32'h0) begin errors++; $display("FAIL rstw_first_addr: got %h expected 0", issued[0]); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL rstw_first_pc: got %h expected 0", if_pc); end
  endtask

  task automatic test_misalign;
    int sz;
    mem_lat = 1;
    sz = issued.size();
    redirect_en = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks += 2;
    if (if_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", if_misalign); end
    if (if_no_op !== 1'b1) begin errors++; $display("FAIL mis_bubble: got %b expected 1", if_no_op); end
    @(negedge clk);
    checks++;
    if (if_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag_clear: got %b expected 0", if_misalign); end
    repeat (8) @(negedge clk);
    checks += 3;
    if (if_no_op !== 1'b1) begin errors++; $display("FAIL mis_halt_no_op: got %b expected 1", if_no_op); end
    if (imem.req !== 1'b0) begin errors++; $display("FAIL mis_halt_req: got %b expected 0", imem.req); end
    if (issued.size() != sz) begin errors++; $display("FAIL mis_no_fetch: got %0d requests expected %0d", issued.size(), sz); end
    redirect_en = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0;
    next_valid("mis_recover");
    checks++;
    if (if_pc !== 32'h100) begin errors++; $display("FAIL mis_recover_pc: got %h expected 100", if_pc); end
`else
    next_valid("mis_aligned");
    checks += 2;
    if (if_pc !== 32'h40) begin errors++; $display("FAIL mis_forced_pc: got %h expected 40", if_pc); end
    if (issued[$] !== 32'h40) begin errors++; $display("FAIL mis_forced_addr: got %h expected 40", issued[$]); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_stall_hold();
    test_redirect_wait();
    test_stall_redirect();
    test_wrap();
    test_reset_in_wait();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
